axi4s_lfsr_err_mon: RTL and testbench
=====================================

# axi4s_lfsr_err_mon

Bit-error monitor that sits directly downstream of the LFSR checker stage. Its input beats carry received-XOR-expected data, so every set bit is one bit error. It runs a lock state machine and per-frame error accumulation, and it emits one status beat per frame on an AXI4-Stream report port. It also keeps running totals for software or a BER readout.

## Interface
- TDATA_WIDTH, 8, input beat width in bits; must be ≥1.
- CNT_WIDTH, 32, width of frame report and total counters; must be ≥ $clog2(TDATA_WIDTH+1).
- LOCK_BEATS, 16, consecutive error-free beats needed to enter LOCKED; must be ≥1.
- UNLOCK_BEATS, 4, consecutive errored beats needed to drop back to HUNT; must be ≥1.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- target_tvalid  in  1  checker beat valid.
- target_tready  out  1  beat accepted when high with tvalid.
- target_tdata  in  TDATA_WIDTH  error pattern; set bit = bit error.
- target_tlast  in  1  last beat of frame.
- status_tvalid  out  1  frame report valid.
- status_tready  in  1  report consumer ready.
- status_tdata  out  CNT_WIDTH  bit errors counted in the reported frame.
- status_tuser  out  1  LOCKED state sampled when the frame's tlast was accepted.
- clear  in  1  synchronous clear of the total counters.
- locked  out  1  1 when state is LOCKED.
- total_beats  out  CNT_WIDTH  beats accepted while LOCKED.
- total_errs  out  CNT_WIDTH  error bits accepted while LOCKED.

## Operation
- A beat is accepted when target_tvalid and target_tready are both high.
- target_tready = !status_tvalid || status_tready. This is combinational, and no other backpressure is applied.
- For each accepted beat, w = popcount(target_tdata), range 0..TDATA_WIDTH.
- Frame accumulator:
  - On every accepted beat, frame_acc += w. This happens in both HUNT and LOCKED. The addition saturates at 2^CNT_WIDTH-1 regardless of the macro.
  - On an accepted tlast beat, status_tdata ← frame_acc + w and status_tuser ← locked, both taken before the lock update. status_tvalid is set and frame_acc resets to 0.
  - A single-beat frame reports just that beat's w.
- status_tvalid clears on a status handshake unless a new tlast is accepted in the same cycle. In that case it stays 1 and status_tdata and status_tuser load the new report, giving back-to-back reports with no bubble.
- Lock FSM, with a run counter sized to max(LOCK_BEATS, UNLOCK_BEATS):
  - HUNT: a clean beat (w==0) increments run; an errored beat resets run to 0. When run reaches LOCK_BEATS, go to LOCKED and reset run to 0.
  - LOCKED: an errored beat increments run; a clean beat resets run to 0. When run reaches UNLOCK_BEATS, go to HUNT and reset run to 0.
  - The state changes on the clock edge that accepts the threshold beat. That beat is classified using the pre-edge state.
- Totals:
  - total_beats += 1 and total_errs += w only for beats accepted while the pre-edge state is LOCKED.
  - Overflow behaviour is set by the Configuration macro.
- clear:
  - Zeroes total_beats and total_errs on the next edge.
  - It has priority over a beat accepted in the same cycle; that beat's contribution to the totals is lost.
  - clear does not affect the FSM, frame_acc, or the status port.
- Reset while aresetn is low:
  - status_tvalid=0, status_tdata=0, status_tuser=0.
  - locked=0 (HUNT), run=0, frame_acc=0, totals=0.
  - target_tready=1.
- Reset mid-frame discards the partial frame, and no report is emitted for it.

## Timing
- Report latency: the status beat is valid on the cycle after the edge that accepts tlast.
- locked reflects the new state on the cycle after the threshold beat is accepted.
- Totals update on the cycle after the beat is accepted. Totals and status outputs are registered.
- With status_tready held high, throughput is one beat per cycle with no stalls.
- With a report pending and status_tready low, target_tready stays low until the report is taken.

## Configuration
- LFSR_MON_SATURATE_EN defined: total_beats and total_errs saturate at 2^CNT_WIDTH-1 and hold until clear.
- LFSR_MON_SATURATE_EN undefined: total_beats and total_errs wrap modulo 2^CNT_WIDTH.
- The macro has no effect on frame_acc, which always saturates.

## Test plan
- Reset, then idle -> all outputs 0 except target_tready=1; locked=0.
- Send 16 clean beats (TDATA_WIDTH=8, defaults) -> locked=1 on the cycle after the 16th beat. A following beat 0x0F gives total_beats=1 and total_errs=4.
- While LOCKED, send 4 consecutive beats of 0xFF -> locked=0 after the 4th beat, and total_errs increases by 32. Interleaving a clean beat after the 3rd errored beat keeps locked=1.
- Frame of 3 beats (0x01, 0x03, 0x80, tlast on the third) with status_tready=1 -> one status beat with tdata=4 on the cycle after the tlast is accepted.
- Two single-beat frames, 0xFF then 0x00, with status_tready=0 for 5 cycles -> the first report (tdata=8) is held, target_tready=0 while it is pending, and the second report (tdata=0) follows after the handshake.
- Assert clear together with an accepted LOCKED beat 0x01 -> totals read 0 on the next cycle. With CNT_WIDTH=4, macro defined and 20 errored bits while LOCKED -> total_errs=15; without the macro -> total_errs=4.

Source files
------------

// File: rtl/axi4s_lfsr_err_mon.sv
// Bit-error monitor after the LFSR checker: lock FSM, per-frame error reports, LOCKED-only running totals.
// Optional macro LFSR_MON_SATURATE_EN: totals saturate instead of wrapping.
module axi4s_lfsr_err_mon #(
    parameter int TDATA_WIDTH  = 8,
    parameter int CNT_WIDTH    = 32,
    parameter int LOCK_BEATS   = 16,
    parameter int UNLOCK_BEATS = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   target_tvalid,
    output logic                   target_tready,
    input  logic [TDATA_WIDTH-1:0] target_tdata,
    input  logic                   target_tlast,
    output logic                   status_tvalid,
    input  logic                   status_tready,
    output logic [CNT_WIDTH-1:0]   status_tdata,
    output logic                   status_tuser,
    input  logic                   clear,
    output logic                   locked,
    output logic [CNT_WIDTH-1:0]   total_beats,
    output logic [CNT_WIDTH-1:0]   total_errs
);
    localparam int RUN_MAX = (LOCK_BEATS > UNLOCK_BEATS) ? LOCK_BEATS : UNLOCK_BEATS;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam logic [RUN_W-1:0]     LOCK_TH   = RUN_W'(LOCK_BEATS);
    localparam logic [RUN_W-1:0]     UNLOCK_TH = RUN_W'(UNLOCK_BEATS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [TDATA_WIDTH-1:0] d);
        logic [CNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < TDATA_WIDTH; i++) begin
            n = n + CNT_WIDTH'(d[i]);
        end
        return n;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_WIDTH] ? CNT_MAX : s[CNT_WIDTH-1:0];
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [RUN_W-1:0]     r_run;
    logic [RUN_W-1:0]     w_run_nxt;
    logic [RUN_W-1:0]     w_run_inc;
    logic [CNT_WIDTH-1:0] r_frame_acc;
    logic [CNT_WIDTH-1:0] w_pop;
    logic [CNT_WIDTH-1:0] w_frame_sum;
    logic                 w_clean;
    logic                 w_accept;
    logic                 w_tready;
    logic                 r_status_tvalid;
    logic [CNT_WIDTH-1:0] r_status_tdata;
    logic                 r_status_tuser;
    logic [CNT_WIDTH-1:0] r_total_beats;
    logic [CNT_WIDTH-1:0] r_total_errs;

    assign w_tready    = !r_status_tvalid || status_tready;
    assign w_accept    = target_tvalid && w_tready;
    assign w_pop       = popcount(target_tdata);
    assign w_clean     = (w_pop == '0);
    assign w_frame_sum = sat_add(r_frame_acc, w_pop);
    assign w_run_inc   = r_run + RUN_W'(1);

    // Lock FSM next state: run counts clean beats in HUNT, errored beats in LOCKED.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (w_accept) begin
            case (r_state)
                ST_HUNT: begin
                    if (!w_clean) begin
                        w_run_nxt = '0;
                    end else if (w_run_inc == LOCK_TH) begin
                        w_state_nxt = ST_LOCKED;
                        w_run_nxt   = '0;
                    end else begin
                        w_run_nxt = w_run_inc;
                    end
                end
                ST_LOCKED: begin
                    if (w_clean) begin
                        w_run_nxt = '0;
                    end else if (w_run_inc == UNLOCK_TH) begin
                        w_state_nxt = ST_HUNT;
                        w_run_nxt   = '0;
                    end else begin
                        w_run_nxt = w_run_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_run_nxt   = '0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
            w_run_nxt   = r_run;
        end
    end

    // Lock FSM state and run counter registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_HUNT;
            r_run   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
        end
    end

    // Frame accumulation and report register; a tlast on the handshake cycle reloads without a bubble.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_frame_acc     <= '0;
            r_status_tvalid <= 1'b0;
            r_status_tdata  <= '0;
            r_status_tuser  <= 1'b0;
        end else if (w_accept && target_tlast) begin
            r_frame_acc     <= '0;
            r_status_tvalid <= 1'b1;
            r_status_tdata  <= w_frame_sum;
            r_status_tuser  <= (r_state == ST_LOCKED);
        end else begin
            if (w_accept) begin
                r_frame_acc <= w_frame_sum;
            end
            if (status_tready) begin
                r_status_tvalid <= 1'b0;
            end
        end
    end

    // Running totals, counted only for beats accepted in LOCKED; clear wins over a same-cycle beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_total_beats <= '0;
            r_total_errs  <= '0;
        end else if (clear) begin
            r_total_beats <= '0;
            r_total_errs  <= '0;
        end else if (w_accept && (r_state == ST_LOCKED)) begin
`ifdef LFSR_MON_SATURATE_EN
            r_total_beats <= sat_add(r_total_beats, CNT_WIDTH'(1));
            r_total_errs  <= sat_add(r_total_errs, w_pop);
`else
            r_total_beats <= r_total_beats + CNT_WIDTH'(1);
            r_total_errs  <= r_total_errs + w_pop;
`endif
        end
    end

    assign target_tready = w_tready;
    assign status_tvalid = r_status_tvalid;
    assign status_tdata  = r_status_tdata;
    assign status_tuser  = r_status_tuser;
    assign locked        = (r_state == ST_LOCKED);
    assign total_beats   = r_total_beats;
    assign total_errs    = r_total_errs;

endmodule

// File: tb/tb_axi4s_lfsr_err_mon.sv
// Self-checking bench for axi4s_lfsr_err_mon: vector table plus report scoreboard and corner sequences.
module tb_axi4s_lfsr_err_mon;

    logic        clk;
    logic        aresetn;
    logic        tv;
    logic        tready;
    logic [7:0]  td;
    logic        tl;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_data;
    logic        st_user;
    logic        clr;
    logic        lk;
    logic [31:0] tot_b;
    logic [31:0] tot_e;

    logic        u2_tv;
    logic        u2_tready;
    logic [7:0]  u2_td;
    logic        u2_st_valid;
    logic [3:0]  u2_st_data;
    logic        u2_st_user;
    logic        u2_lk;
    logic [3:0]  u2_tot_b;
    logic [3:0]  u2_tot_e;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       exp_locked;
        int         exp_tb;
        int         exp_te;
        logic       exp_sv;
        int         exp_rdata;
        logic       exp_ruser;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        u;
    } rep_t;

    localparam int NV = 31;
    vec_t vecs[NV];
    rep_t sb_q[$];

    axi4s_lfsr_err_mon dut (
        .aclk(clk), .aresetn(aresetn),
        .target_tvalid(tv), .target_tready(tready), .target_tdata(td), .target_tlast(tl),
        .status_tvalid(st_valid), .status_tready(st_ready), .status_tdata(st_data),
        .status_tuser(st_user), .clear(clr), .locked(lk),
        .total_beats(tot_b), .total_errs(tot_e)
    );

    axi4s_lfsr_err_mon #(.CNT_WIDTH(4)) dut4 (
        .aclk(clk), .aresetn(aresetn),
        .target_tvalid(u2_tv), .target_tready(u2_tready), .target_tdata(u2_td), .target_tlast(1'b0),
        .status_tvalid(u2_st_valid), .status_tready(1'b1), .status_tdata(u2_st_data),
        .status_tuser(u2_st_user), .clear(1'b0), .locked(u2_lk),
        .total_beats(u2_tot_b), .total_errs(u2_tot_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_row(input int i, input logic [7:0] d, input logic l, input logic lkd,
                           input int tb, input int te, input logic sv, input int rd, input logic ru);
        vecs[i].data       = d;
        vecs[i].last       = l;
        vecs[i].exp_locked = lkd;
        vecs[i].exp_tb     = tb;
        vecs[i].exp_te     = te;
        vecs[i].exp_sv     = sv;
        vecs[i].exp_rdata  = rd;
        vecs[i].exp_ruser  = ru;
    endtask

    task automatic push_rep(input int d, input logic u);
        rep_t r;
        r.d = d;
        r.u = u;
        sb_q.push_back(r);
    endtask

    // Report monitor: pops the scoreboard on every status handshake.
    initial begin
        rep_t r;
        forever begin
            @(negedge clk);
            #1;
            if (aresetn && st_valid && st_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL report_unexpected actual=%0d required=none", st_data);
                end else begin
                    r = sb_q.pop_front();
                    chk("report_tdata", st_data, r.d);
                    chk("report_tuser", {31'd0, st_user}, {31'd0, r.u});
                end
            end
        end
    end

    initial begin
        aresetn  = 1'b0;
        tv       = 1'b0;
        td       = 8'h00;
        tl       = 1'b0;
        st_ready = 1'b1;
        clr      = 1'b0;
        u2_tv    = 1'b0;
        u2_td    = 8'h00;

        for (int i = 0; i < 15; i++) set_row(i, 8'h00, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        set_row(15, 8'h00, 1'b0, 1'b1, 0, 0, 1'b0, 0, 1'b0);
        set_row(16, 8'h0F, 1'b0, 1'b1, 1, 4, 1'b0, 0, 1'b0);
        set_row(17, 8'h00, 1'b0, 1'b1, 2, 4, 1'b0, 0, 1'b0);
        set_row(18, 8'hFF, 1'b0, 1'b1, 3, 12, 1'b0, 0, 1'b0);
        set_row(19, 8'hFF, 1'b0, 1'b1, 4, 20, 1'b0, 0, 1'b0);
        set_row(20, 8'hFF, 1'b0, 1'b1, 5, 28, 1'b0, 0, 1'b0);
        set_row(21, 8'h00, 1'b0, 1'b1, 6, 28, 1'b0, 0, 1'b0);
        set_row(22, 8'hFF, 1'b0, 1'b1, 7, 36, 1'b0, 0, 1'b0);
        set_row(23, 8'hFF, 1'b0, 1'b1, 8, 44, 1'b0, 0, 1'b0);
        set_row(24, 8'hFF, 1'b0, 1'b1, 9, 52, 1'b0, 0, 1'b0);
        set_row(25, 8'hFF, 1'b1, 1'b0, 10, 60, 1'b1, 60, 1'b1);
        set_row(26, 8'h01, 1'b0, 1'b0, 10, 60, 1'b0, 0, 1'b0);
        set_row(27, 8'h03, 1'b0, 1'b0, 10, 60, 1'b0, 0, 1'b0);
        set_row(28, 8'h80, 1'b1, 1'b0, 10, 60, 1'b1, 4, 1'b0);
        set_row(29, 8'h00, 1'b1, 1'b0, 10, 60, 1'b1, 0, 1'b0);
        set_row(30, 8'h00, 1'b0, 1'b0, 10, 60, 1'b0, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst_tready", {31'd0, tready}, 32'd1);
        chk("rst_svalid", {31'd0, st_valid}, 32'd0);
        chk("rst_locked", {31'd0, lk}, 32'd0);
        aresetn = 1'b1;
        @(negedge clk);
        chk("idle_tready", {31'd0, tready}, 32'd1);
        chk("idle_svalid", {31'd0, st_valid}, 32'd0);
        chk("idle_sdata", st_data, 32'd0);
        chk("idle_suser", {31'd0, st_user}, 32'd0);
        chk("idle_locked", {31'd0, lk}, 32'd0);
        chk("idle_tbeats", tot_b, 32'd0);
        chk("idle_terrs", tot_e, 32'd0);

        // Table: lock, unlock, multi-beat and back-to-back frames at full rate.
        for (int i = 0; i < NV; i++) begin
            tv = 1'b1;
            td = vecs[i].data;
            tl = vecs[i].last;
            if (vecs[i].last) push_rep(vecs[i].exp_rdata, vecs[i].exp_ruser);
            @(negedge clk);
            chk($sformatf("row%0d_locked", i), {31'd0, lk}, {31'd0, vecs[i].exp_locked});
            chk($sformatf("row%0d_tbeats", i), tot_b, vecs[i].exp_tb);
            chk($sformatf("row%0d_terrs", i), tot_e, vecs[i].exp_te);
            chk($sformatf("row%0d_svalid", i), {31'd0, st_valid}, {31'd0, vecs[i].exp_sv});
        end
        tv = 1'b0;
        tl = 1'b0;
        @(negedge clk);

        // Backpressure: first report held, input stalled, second report follows.
        st_ready = 1'b0;
        tv = 1'b1;
        td = 8'hFF;
        tl = 1'b1;
        push_rep(8, 1'b0);
        @(negedge clk);
        td = 8'h00;
        push_rep(0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_tready", {31'd0, tready}, 32'd0);
            chk("bp_svalid", {31'd0, st_valid}, 32'd1);
            chk("bp_sdata", st_data, 32'd8);
            @(negedge clk);
        end
        st_ready = 1'b1;
        @(negedge clk);
        tv = 1'b0;
        tl = 1'b0;
        chk("bp2_svalid", {31'd0, st_valid}, 32'd1);
        chk("bp2_sdata", st_data, 32'd0);
        @(negedge clk);
        chk("bp_drain_svalid", {31'd0, st_valid}, 32'd0);

        // Relock, then clear coinciding with a LOCKED beat.
        tv = 1'b1;
        td = 8'h00;
        repeat (16) @(negedge clk);
        chk("relock_locked", {31'd0, lk}, 32'd1);
        td = 8'h01;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tv = 1'b0;
        chk("clear_tbeats", tot_b, 32'd0);
        chk("clear_terrs", tot_e, 32'd0);
        chk("clear_locked", {31'd0, lk}, 32'd1);
        tv = 1'b1;
        @(negedge clk);
        tv = 1'b0;
        chk("postclr_tbeats", tot_b, 32'd1);
        chk("postclr_terrs", tot_e, 32'd1);

        // Reset mid-frame drops the partial frame.
        aresetn = 1'b0;
        @(negedge clk);
        chk("midrst_locked", {31'd0, lk}, 32'd0);
        chk("midrst_tbeats", tot_b, 32'd0);
        chk("midrst_tready", {31'd0, tready}, 32'd1);
        aresetn = 1'b1;
        @(negedge clk);
        tv = 1'b1;
        td = 8'h01;
        tl = 1'b1;
        push_rep(1, 1'b0);
        @(negedge clk);
        tv = 1'b0;
        tl = 1'b0;
        chk("midrst_svalid", {31'd0, st_valid}, 32'd1);
        chk("midrst_sdata", st_data, 32'd1);
        @(negedge clk);

        // Narrow counters: 20 error bits while LOCKED.
        u2_tv = 1'b1;
        u2_td = 8'h00;
        repeat (16) @(negedge clk);
        u2_td = 8'hFF; @(negedge clk);
        u2_td = 8'h00; @(negedge clk);
        u2_td = 8'hFF; @(negedge clk);
        u2_td = 8'h00; @(negedge clk);
        u2_td = 8'h0F; @(negedge clk);
        u2_tv = 1'b0;
        chk("n4_locked", {31'd0, u2_lk}, 32'd1);
        chk("n4_tbeats", {28'd0, u2_tot_b}, 32'd5);
`ifdef LFSR_MON_SATURATE_EN
        chk("n4_terrs", {28'd0, u2_tot_e}, 32'd15);
`else
        chk("n4_terrs", {28'd0, u2_tot_e}, 32'd4);
`endif
        chk("n4_svalid", {31'd0, u2_st_valid}, 32'd0);
        chk("n4_sdata", {28'd0, u2_st_data}, 32'd0);
        chk("n4_suser", {31'd0, u2_st_user}, 32'd0);
        chk("n4_tready", {31'd0, u2_tready}, 32'd1);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
